servo_move_sequencer: RTL and testbench
=======================================

Name: servo_move_sequencer

Overview:
- Sequences cube-gripper/rotator servo moves for the PWM servo drivers.
- Accepts one move command at a time over a valid/ready handshake.
- Ramps the selected servo's duty value toward the target in fixed steps, one step per PWM frame, then holds for a dwell time so the mechanism can settle.
- Drives one duty word per servo and a shared period word to the pwm_servos instances, and reports move completion to the solver FSM.

Parameters:
- NSERVO, 4, number of servos driven; index range 0..NSERVO-1.
- SELW, 2, width of the servo select field; must satisfy 2^SELW >= NSERVO.
- PERIOD, 2000, clock cycles per PWM frame; also driven on t_out.
- DMIN, 100, minimum legal duty value.
- DMAX, 200, maximum legal duty value.
- DINIT, 150, duty value of every servo after reset (neutral).
- STEP, 5, maximum duty change per frame during a ramp.
- DWELL, 10, settle time in frames after the target is reached.

Ports:
- clk  in  1  system clock
- res  in  1  asynchronous active-low reset
- cmd_valid  in  1  move command present
- cmd_ready  out  1  sequencer idle; command accepted when cmd_valid && cmd_ready
- cmd_sel  in  SELW  servo index
- cmd_duty  in  32  target duty, unsigned
- duty_bus  out  NSERVO*32  per-servo duty; servo k occupies bits [32k+31:32k]
- t_out  out  32  PWM period, constant PERIOD
- frame_tick  out  1  one-cycle pulse at end of each frame
- busy  out  1  high in RAMP or DWELL
- done  out  1  one-cycle pulse when a move completes
- err  out  1  one-cycle pulse when a command with cmd_sel >= NSERVO is rejected

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE; frame counter=0.
  - All duty_bus words = DINIT.
  - frame_tick=0, done=0, err=0, busy=0, cmd_ready=1.
  - Reset takes effect immediately, including mid-move; no completion pulse is issued for an aborted move.
- Frame counter:
  - Free-running 0..PERIOD-1, wraps to 0.
  - frame_tick=1 exactly in the cycle where count==PERIOD-1.
  - Runs independently of the state machine.
- Command acceptance: cmd_ready = (state==IDLE). On acceptance, cmd_sel, the target and the current duty are latched.
  - If cmd_sel >= NSERVO: err pulses on the next cycle, state stays IDLE, no duty changes.
  - Otherwise: target = clamp(cmd_duty, DMIN, DMAX) and state becomes RAMP on the next cycle.
- RAMP: on each frame_tick the selected duty moves toward the target.
  - Update rule: cur += min(STEP, tgt-cur) if cur<tgt; cur -= min(STEP, cur-tgt) if cur>tgt; unchanged if equal.
  - The new value appears on duty_bus the cycle after the tick.
  - If the value after the update equals the target (including target==current at acceptance), go to DWELL with dwell counter=0.
  - A tick coincident with the acceptance cycle is ignored.
- DWELL: the dwell counter increments on each frame_tick.
  - When it reaches DWELL: done pulses for one cycle, state returns to IDLE, and cmd_ready=1 in that same cycle.
- Non-selected servos: duty words never change during a move.
- Arithmetic: 32-bit unsigned; no wrap. Clamping guarantees every duty stays in [DMIN, DMAX].
- Input handling: cmd_valid held high while busy is neither accepted nor lost; cmd fields are sampled only at acceptance.

Test Plan:
Bench parameters: PERIOD=20, STEP=5, DWELL=2, NSERVO=3.
1. Reset then idle. Required: all three duty words = 150; t_out=20; frame_tick every 20 cycles; cmd_ready=1.
2. Command sel=1, duty=200. Required:
   - duty[1] steps 155, 160, …, 200 over 10 frame ticks; reaches 200 at tick 10.
   - done pulses once at tick 12.
   - duty[0] and duty[2] stay at 150.
   - busy is high throughout the move.
3. Command sel=2, duty=250, then sel=2, duty=40. Required:
   - duty[2] clamps to 200.
   - It then ramps down 195 … 100 and stops at 100.
   - Each move produces one done pulse.
4. Command sel=3, duty=180. Required: err pulses one cycle; no done; duties unchanged; cmd_ready stays 1.
5. Back-to-back commands with cmd_valid held high. Required:
   - The second command (sel=0, duty=120) is not accepted until the first move's done.
   - It is accepted in the done cycle.
   - duty[0] ramps 145 … 120.
6. Deassert res during the ramp of sel=1 to 200 (duty=170). Required:
   - duty[1] returns to 150 immediately.
   - No done pulse.
   - After reset release: cmd_ready=1 and the frame counter restarts at 0.

Source files
------------

// File: rtl/servo_move_sequencer.sv
// Servo move sequencer: accepts one move at a time, ramps the selected
// servo's duty toward a clamped target one step per PWM frame, then dwells
// for a fixed number of frames before reporting completion.
module servo_move_sequencer #(
  parameter int NSERVO = 4,
  parameter int SELW   = 2,
  parameter int PERIOD = 2000,
  parameter int DMIN   = 100,
  parameter int DMAX   = 200,
  parameter int DINIT  = 150,
  parameter int STEP   = 5,
  parameter int DWELL  = 10   // must be >= 1
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SELW-1:0]        cmd_sel,
  input  logic [31:0]            cmd_duty,
  output logic [NSERVO*32-1:0]   duty_bus,
  output logic [31:0]            t_out,
  output logic                   frame_tick,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_DWELL} state_t;

  localparam logic [31:0] L_PERIOD = 32'(PERIOD);
  localparam logic [31:0] L_NSERVO = 32'(NSERVO);
  localparam logic [31:0] L_DMIN   = 32'(DMIN);
  localparam logic [31:0] L_DMAX   = 32'(DMAX);
  localparam logic [31:0] L_DINIT  = 32'(DINIT);
  localparam logic [31:0] L_STEP   = 32'(STEP);
  localparam logic [31:0] L_DWELL  = 32'(DWELL);

  state_t                  r_state, w_state_nxt;
  logic [31:0]             r_cnt, r_tgt, r_cur, r_dwell;
  logic [SELW-1:0]         r_sel;
  logic [NSERVO-1:0][31:0] r_duty;
  logic                    r_done, r_err;

  logic        w_tick, w_accept, w_sel_ok, w_up;
  logic [31:0] w_clamp, w_sel_duty, w_diff, w_mv, w_step, w_dwell_inc;

  assign w_tick      = (r_cnt == L_PERIOD - 32'd1);
  assign w_accept    = cmd_valid && (r_state == S_IDLE);
  assign w_sel_ok    = ({{(32-SELW){1'b0}}, cmd_sel} < L_NSERVO);
  assign w_clamp     = (cmd_duty < L_DMIN) ? L_DMIN :
                       (cmd_duty > L_DMAX) ? L_DMAX : cmd_duty;
  // Step toward target, never overshooting; no wrap since both ends are in range.
  assign w_up        = (r_tgt > r_cur);
  assign w_diff      = w_up ? (r_tgt - r_cur) : (r_cur - r_tgt);
  assign w_mv        = (w_diff < L_STEP) ? w_diff : L_STEP;
  assign w_step      = w_up ? (r_cur + w_mv) : (r_cur - w_mv);
  assign w_dwell_inc = r_dwell + 32'd1;

  // Current duty of the servo named by the incoming command (mux safe for out-of-range sel).
  always_comb begin
    w_sel_duty = L_DINIT;
    for (int k = 0; k < NSERVO; k++)
      if (cmd_sel == SELW'(k)) w_sel_duty = r_duty[k];
  end

  // Free-running frame counter, independent of the move FSM.
  always_ff @(posedge clk or negedge res) begin
    if (!res)        r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 32'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state: a zero-length ramp goes straight to dwell.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_sel_ok)
                 w_state_nxt = (w_clamp == w_sel_duty) ? S_DWELL : S_RAMP;
      S_RAMP:  if (w_tick && (w_step == r_tgt)) w_state_nxt = S_DWELL;
      S_DWELL: if (w_tick && (w_dwell_inc == L_DWELL)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Move context, dwell counter and one-cycle done/err pulses.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_sel   <= '0;
      r_tgt   <= L_DINIT;
      r_cur   <= L_DINIT;
      r_dwell <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err  <= w_accept && !w_sel_ok;
      r_done <= (r_state == S_DWELL) && w_tick && (w_dwell_inc == L_DWELL);
      if (w_accept) begin
        r_sel   <= cmd_sel;
        r_tgt   <= w_clamp;
        r_cur   <= w_sel_duty;
        r_dwell <= '0;
      end else if (r_state == S_RAMP && w_tick) begin
        r_cur   <= w_step;
        r_dwell <= '0;
      end else if (r_state == S_DWELL && w_tick) begin
        r_dwell <= w_dwell_inc;
      end
    end
  end

  // Per-servo duty words; only the selected one moves, on ramp ticks.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int k = 0; k < NSERVO; k++) r_duty[k] <= L_DINIT;
    end else begin
      for (int k = 0; k < NSERVO; k++)
        if (r_state == S_RAMP && w_tick && r_sel == SELW'(k)) r_duty[k] <= w_step;
    end
  end

  assign duty_bus   = r_duty;
  assign t_out      = L_PERIOD;
  assign frame_tick = w_tick;
  assign busy       = (r_state != S_IDLE);
  assign cmd_ready  = (r_state == S_IDLE);
  assign done       = r_done;
  assign err        = r_err;
endmodule

// File: tb/tb_servo_move_sequencer.sv
// Randomized + directed bench for servo_move_sequencer. The reference model
// predicts each move from its endpoints: number of ramp ticks, value after
// n ticks, and the tick count at which done must fire.
module tb_servo_move_sequencer;
  localparam int NS = 3, PER = 20, STP = 5, DW = 2, DLO = 100, DHI = 200, DI = 150;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_sel = '0;
  logic [31:0]   cmd_duty = '0;
  logic [NS*32-1:0] duty_bus;
  logic [31:0]   t_out;
  logic          frame_tick, busy, done, err;

  int n_chk = 0, n_err = 0;
  int ncyc  = 0;
  int exp_duty [NS];

  servo_move_sequencer #(.NSERVO(NS), .SELW(2), .PERIOD(PER), .DMIN(DLO), .DMAX(DHI),
                         .DINIT(DI), .STEP(STP), .DWELL(DW)) dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_duty(cmd_duty), .duty_bus(duty_bus), .t_out(t_out),
    .frame_tick(frame_tick), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  function automatic logic [NS*32-1:0] exp_vec();
    logic [NS*32-1:0] v;
    for (int k = 0; k < NS; k++) v[k*32 +: 32] = 32'(exp_duty[k]);
    return v;
  endfunction

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    ncyc++;
    @(negedge clk);
  endtask

  function automatic bit tick_now();
    return (ncyc % PER) == PER - 1;
  endfunction

  task automatic do_reset();
    res = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NS; k++) exp_duty[k] = DI;
    res = 1'b1;
    ncyc = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_tick", frame_tick, tick_now());
      chk("idle_ready", cmd_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_duty", duty_bus, exp_vec());
      step();
    end
  endtask

  // Issue one command and follow it to completion. With chain set, cmd_valid
  // stays high carrying the next command's fields for the whole move.
  task automatic move(input int sel, input int duty, input bit chain, input int nsel, input int nduty);
    int ca, tgt, cur, diff, nramp, total, ticks, moved, lim;
    bit fin, prev_tick;
    lim = 0;
    while (!cmd_ready && lim < 1000) begin step(); lim++; end
    chk("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_sel   = 2'(sel);
    cmd_duty  = 32'(duty);
    ca = ncyc;
    if (sel >= NS) begin
      step();
      cmd_valid = 1'b0;
      chk("err_pulse", err, 1'b1);
      chk("err_busy", busy, 1'b0);
      chk("err_ready", cmd_ready, 1'b1);
      chk("err_duty", duty_bus, exp_vec());
      step();
      chk("err_once", err, 1'b0);
      chk("err_nodone", done, 1'b0);
      chk("err_duty2", duty_bus, exp_vec());
      return;
    end
    tgt   = (duty < DLO) ? DLO : (duty > DHI) ? DHI : duty;
    cur   = exp_duty[sel];
    diff  = (tgt > cur) ? tgt - cur : cur - tgt;
    nramp = (diff + STP - 1) / STP;
    total = nramp + DW;
    ticks = 0;
    fin   = 1'b0;
    for (int n = 0; n < (total + 2) * PER + 4 && !fin; n++) begin
      prev_tick = tick_now() && (ncyc != ca);
      step();
      if (n == 0) begin
        cmd_valid = chain;
        if (chain) begin cmd_sel = 2'(nsel); cmd_duty = 32'(nduty); end
      end
      if (prev_tick) ticks++;
      moved = (ticks * STP < diff) ? ticks * STP : diff;
      exp_duty[sel] = (tgt >= cur) ? cur + moved : cur - moved;
      chk("mv_duty", duty_bus, exp_vec());
      chk("mv_tick", frame_tick, tick_now());
      chk("mv_done", done, prev_tick && ticks == total);
      chk("mv_busy", busy, ticks < total);
      chk("mv_ready", cmd_ready, ticks >= total);
      chk("mv_err", err, 1'b0);
      if (prev_tick && ticks == total) fin = 1'b1;
    end
    if (!fin) chk("mv_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lim, s, d;
    @(negedge clk);
    // 1: reset and idle
    do_reset();
    chk("rst_duty", duty_bus, exp_vec());
    chk("rst_tout", t_out, 32'd20);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    idle(45);
    // 2: ramp up to top
    move(1, 200, 1'b0, 0, 0);
    chk("t2_d1", duty_bus[63:32], 32'd200);
    idle(3);
    // 3: clamp high, then clamp low
    move(2, 250, 1'b0, 0, 0);
    chk("t3_hi", duty_bus[95:64], 32'd200);
    idle(5);
    move(2, 40, 1'b0, 0, 0);
    chk("t3_lo", duty_bus[95:64], 32'd100);
    // 4: out-of-range selector
    move(3, 180, 1'b0, 0, 0);
    idle(4);
    // 5: back-to-back with valid held
    move(1, 150, 1'b1, 0, 120);
    move(0, 120, 1'b0, 0, 0);
    chk("t5_d0", duty_bus[31:0], 32'd120);
    idle(2);
    // 6: reset mid-ramp
    cmd_valid = 1'b1; cmd_sel = 2'd1; cmd_duty = 32'd200;
    step();
    cmd_valid = 1'b0;
    lim = 0;
    while (duty_bus[63:32] != 32'd170 && lim < 500) begin step(); lim++; end
    chk("t6_reach170", duty_bus[63:32], 32'd170);
    #2 res = 1'b0;
    #1;
    for (int k = 0; k < NS; k++) exp_duty[k] = DI;
    chk("t6_duty", duty_bus, exp_vec());
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", cmd_ready, 1'b1);
    chk("t6_tick", frame_tick, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_nodone", done, 1'b0);
    end
    res = 1'b1;
    ncyc = 0;
    idle(25);
    // Random moves against the model
    for (int r = 0; r < 12; r++) begin
      s = $urandom_range(0, 3);
      d = $urandom_range(0, 300);
      if (s < NS && $urandom_range(0, 4) == 0) d = exp_duty[s];
      move(s, d, 1'b0, 0, 0);
      idle($urandom_range(0, 25));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
